// File: rtl/bdpsk_symbol_sequencer_pkg.sv
// Shared constants and FSM encoding for the BDPSK symbol sequencer.
// The half-period offset is the ROM address step that yields a 180-degree carrier shift.
package bdpsk_symbol_sequencer_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int CARRIER_W  = 4;

  function automatic int half_offset(input int addr_w);
    return 1 << (addr_w - 1);
  endfunction

  localparam int HALF_OFS = half_offset(ADDR_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bdpsk_symbol_sequencer_if.sv
// Bit-input handshake and DA-side signals of the BDPSK symbol sequencer.
// Handshake: bit_in is transferred on a rising clk edge where bit_valid and bit_ready are both 1;
// the source holds bit_in/bit_valid until that edge, bit_ready may depend on the current cycle's state.
interface bdpsk_symbol_sequencer_if #(
  parameter int ADDR_W = bdpsk_symbol_sequencer_pkg::ADDR_W_DEF
);

  logic              en;
  logic              re;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [ADDR_W-1:0] address;
  logic              clk_DA;
  logic              blank_DA_n;
  logic              sync_DA_n;
  logic              sym_start;
  logic              underrun;

  modport master (
    output en, re, bit_in, bit_valid,
    input  bit_ready, address, clk_DA, blank_DA_n, sync_DA_n, sym_start, underrun
  );

  modport slave (
    input  en, re, bit_in, bit_valid,
    output bit_ready, address, clk_DA, blank_DA_n, sync_DA_n, sym_start, underrun
  );

endinterface

// File: rtl/bdpsk_bit_buffer.sv
// One-entry holding register for the next data bit, with a bypass path so that a bit
// arriving in the same cycle as a symbol start is used immediately.
module bdpsk_bit_buffer (
  input  logic clk,
  input  logic rst_n,
  input  logic i_bit,
  input  logic i_valid,
  input  logic i_consume,
  output logic o_ready,
  output logic o_full,
  output logic o_have,
  output logic o_bit
);

  logic r_full;
  logic r_bit;

  // A consume frees the entry this cycle, so a new bit may be accepted alongside it.
  assign o_ready = !r_full || i_consume;
  assign o_full  = r_full;
  assign o_have  = r_full || i_valid;
  assign o_bit   = r_full ? r_bit : i_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_bit  <= 1'b0;
    end else if (i_consume) begin
      // Empty + valid is the bypass case: the bit is used directly and never stored.
      r_full <= r_full && i_valid;
      if (r_full && i_valid) begin
        r_bit <= i_bit;
      end
    end else if (!r_full && i_valid) begin
      r_full <= 1'b1;
      r_bit  <= i_bit;
    end
  end

endmodule

// File: rtl/bdpsk_symbol_sequencer.sv
// BDPSK transmitter sequencer: walks a sine-ROM address through CYC_PER_SYM carrier periods
// per symbol and flips the carrier by half a period according to the (differential) data bit.
module bdpsk_symbol_sequencer
  import bdpsk_symbol_sequencer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CYC_PER_SYM = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  bdpsk_symbol_sequencer_if.slave        bus,
  output state_t                         o_dbg_state
);

  localparam logic [ADDR_W-1:0]    HALF     = ADDR_W'(half_offset(ADDR_W));
  localparam logic [CARRIER_W-1:0] LAST_CYC = CARRIER_W'(CYC_PER_SYM - 1);

  state_t               r_state;
  logic [ADDR_W-1:0]    r_sample;
  logic [CARRIER_W-1:0] r_carrier;
  logic [ADDR_W-1:0]    r_address;
  logic                 r_phase;
  logic                 r_sym_start;
  logic                 r_underrun;
  logic                 r_blank_n;

  logic                 w_full;
  logic                 w_have;
  logic                 w_bit;
  logic                 w_active;
  logic                 w_sym_end;
  logic                 w_start;
  logic                 w_b;
  logic                 w_phase_nxt;
  logic [ADDR_W-1:0]    w_sample_nxt;
  logic [CARRIER_W-1:0] w_carrier_nxt;
  logic [ADDR_W-1:0]    w_addr_nxt;

  bdpsk_bit_buffer u_bit_buffer (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_bit     (bus.bit_in),
    .i_valid   (bus.bit_valid),
    .i_consume (w_start),
    .o_ready   (bus.bit_ready),
    .o_full    (w_full),
    .o_have    (w_have),
    .o_bit     (w_bit)
  );

  assign w_active  = (r_state != ST_IDLE);
  assign w_sym_end = w_active && (&r_sample) && (r_carrier == LAST_CYC);

  // A symbol starts either from IDLE with a bit waiting, or back-to-back after the last sample.
  assign w_start = w_active ? (w_sym_end && bus.en) : (bus.en && w_full);

  // An empty holding register at a symbol start transmits a 0 bit.
  assign w_b         = w_have && w_bit;
  assign w_phase_nxt = !w_start ? r_phase : (bus.re ? (r_phase ^ w_b) : w_b);

  always_comb begin
    w_sample_nxt  = '0;
    w_carrier_nxt = '0;
    if (w_active && !w_sym_end) begin
      w_sample_nxt  = r_sample + 1'b1;
      w_carrier_nxt = (&r_sample) ? (r_carrier + 1'b1) : r_carrier;
    end
  end

  assign w_addr_nxt = w_sample_nxt + (w_phase_nxt ? HALF : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_sample    <= '0;
      r_carrier   <= '0;
      r_address   <= '0;
      r_phase     <= 1'b0;
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
      r_blank_n   <= 1'b0;
    end else begin
      r_sample    <= w_sample_nxt;
      r_carrier   <= w_carrier_nxt;
      r_phase     <= w_phase_nxt;
      r_sym_start <= w_start;
      r_underrun  <= w_start && !w_have;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_RUN;
            r_blank_n <= 1'b1;
            r_address <= w_addr_nxt;
          end else begin
            r_blank_n <= 1'b0;
            r_address <= '0;
          end
        end
        default: begin
          // Dropping en only takes effect once the current symbol has been fully sent.
          if (w_sym_end && !bus.en) begin
            r_state   <= ST_IDLE;
            r_blank_n <= 1'b0;
            r_address <= '0;
          end else begin
            r_state   <= bus.en ? ST_RUN : ST_FINISH;
            r_blank_n <= 1'b1;
            r_address <= w_addr_nxt;
          end
        end
      endcase
    end
  end

  assign bus.address    = r_address;
  assign bus.clk_DA     = clk;
  assign bus.blank_DA_n = r_blank_n;
  assign bus.sync_DA_n  = 1'b1;
  assign bus.sym_start  = r_sym_start;
  assign bus.underrun   = r_underrun;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_bdpsk_symbol_sequencer.sv
// Directed bench for the BDPSK symbol sequencer: absolute/relative encoding, underrun,
// bypass, graceful stop and asynchronous mid-symbol reset.
module tb_bdpsk_symbol_sequencer;
  import bdpsk_symbol_sequencer_pkg::*;

  localparam int ADDR_W = 5;

  logic   clk = 1'b0;
  logic   reset_n;
  state_t dbg_state;
  int     errors = 0;
  int     checks = 0;
  logic   feed_q[$];

  bdpsk_symbol_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  bdpsk_symbol_sequencer #(.ADDR_W(ADDR_W), .CYC_PER_SYM(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    reset_n       = 1'b0;
    bus.en        = 1'b0;
    bus.re        = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    feed_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Driver: one clock per call; offers the queue head and pops it if the transfer will occur.
  task automatic step(input logic en_v);
    @(negedge clk);
    bus.en = en_v;
    if (feed_q.size() > 0) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = feed_q[0];
    end else begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
    end
    #1;
    if (bus.bit_valid && bus.bit_ready) void'(feed_q.pop_front());
  endtask

  task automatic test_reset;
    reset_n = 1'b0; bus.en = 1'b0; bus.re = 1'b0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", bus.address); end
    checks++; if (bus.blank_DA_n !== 1'b0) begin errors++; $display("FAIL rst_blank: got %b expected 0", bus.blank_DA_n); end
    checks++; if (bus.sym_start !== 1'b0) begin errors++; $display("FAIL rst_sym_start: got %b expected 0", bus.sym_start); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b expected 0", bus.underrun); end
    checks++; if (bus.bit_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.bit_ready); end
    checks++; if (bus.sync_DA_n !== 1'b1) begin errors++; $display("FAIL rst_sync: got %b expected 1", bus.sync_DA_n); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if (bus.clk_DA !== 1'b0) begin errors++; $display("FAIL clk_da_low: got %b expected 0", bus.clk_DA); end
    @(posedge clk); #1;
    checks++; if (bus.clk_DA !== 1'b1) begin errors++; $display("FAIL clk_da_high: got %b expected 1", bus.clk_DA); end
    reset_n = 1'b1;
  endtask

  // Shared by absolute and relative modes: three symbols, en dropped at sample 40 of the third.
  task automatic test_three_symbols(input logic re_v, input logic b0, input logic b1, input logic b2,
                                    input logic p0, input logic p1, input logic p2, input string tag);
    logic              ph [3];
    logic [ADDR_W-1:0] exp_a;
    int                k;
    ph = '{p0, p1, p2};
    do_reset();
    bus.re = re_v;
    feed_q = '{b0, b1, b2};
    for (int s = 1; s <= 390; s++) begin
      step(s < 299);
      k = s - 3;
      if (s == 1) begin
        checks++; if (bus.blank_DA_n !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL %s_idle: got blank=%b state=%0d expected blank=0 state=0", tag, bus.blank_DA_n, dbg_state); end
      end
      if (k >= 0 && k < 384) begin
        exp_a = ADDR_W'((k % 32) + (ph[k / 128] ? 16 : 0));
        checks++; if (bus.address !== exp_a) begin errors++; $display("FAIL %s_addr k=%0d: got %0d expected %0d", tag, k, bus.address, exp_a); end
        checks++; if (bus.sym_start !== (k % 128 == 0)) begin errors++; $display("FAIL %s_sym_start k=%0d: got %b expected %b", tag, k, bus.sym_start, (k % 128 == 0)); end
        checks++; if (bus.blank_DA_n !== 1'b1 || bus.underrun !== 1'b0) begin errors++; $display("FAIL %s_run k=%0d: got blank=%b underrun=%b expected 1 0", tag, k, bus.blank_DA_n, bus.underrun); end
      end
      if (k == 10) begin
        checks++; if (bus.bit_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_full: got %b expected 0", tag, bus.bit_ready); end
      end
      if (k == 300) begin
        checks++; if (dbg_state !== ST_FINISH) begin errors++; $display("FAIL %s_finish: got %0d expected %0d", tag, dbg_state, ST_FINISH); end
      end
      if (k >= 384) begin
        checks++; if (bus.blank_DA_n !== 1'b0 || bus.address !== 5'd0 || bus.sym_start !== 1'b0 || dbg_state !== ST_IDLE) begin
          errors++; $display("FAIL %s_stop k=%0d: got blank=%b addr=%0d sym=%b state=%0d expected 0 0 0 0", tag, k, bus.blank_DA_n, bus.address, bus.sym_start, dbg_state);
        end
      end
    end
  endtask

  task automatic test_absolute;
    test_three_symbols(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "abs");
  endtask

  task automatic test_relative;
    test_three_symbols(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rel");
  endtask

  // One queued bit, an underrun, a same-cycle bypass bit, then a second underrun.
  task automatic test_underrun_bypass;
    logic              ph [4];
    logic [ADDR_W-1:0] exp_a;
    logic              exp_u;
    int                k;
    ph = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    bus.re = 1'b1;
    feed_q = '{1'b1};
    for (int s = 1; s <= 518; s++) begin
      if (s == 258) feed_q.push_back(1'b1);
      step(s < 403);
      k = s - 3;
      if (k >= 0 && k < 512) begin
        exp_a = ADDR_W'((k % 32) + (ph[k / 128] ? 16 : 0));
        exp_u = (k == 128) || (k == 384);
        checks++; if (bus.address !== exp_a) begin errors++; $display("FAIL ur_addr k=%0d: got %0d expected %0d", k, bus.address, exp_a); end
        checks++; if (bus.underrun !== exp_u) begin errors++; $display("FAIL ur_underrun k=%0d: got %b expected %b", k, bus.underrun, exp_u); end
        checks++; if (bus.sym_start !== (k % 128 == 0)) begin errors++; $display("FAIL ur_sym_start k=%0d: got %b expected %b", k, bus.sym_start, (k % 128 == 0)); end
      end
      if (k == 512) begin
        checks++; if (bus.blank_DA_n !== 1'b0 || bus.address !== 5'd0) begin errors++; $display("FAIL ur_stop: got blank=%b addr=%0d expected 0 0", bus.blank_DA_n, bus.address); end
      end
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    bus.re = 1'b0;
    feed_q = '{1'b1, 1'b1};
    for (int s = 1; s <= 73; s++) step(1'b1);
    checks++; if (bus.address !== 5'd22) begin errors++; $display("FAIL mr_addr70: got %0d expected 22", bus.address); end
    checks++; if (bus.bit_ready !== 1'b0) begin errors++; $display("FAIL mr_ready70: got %b expected 0", bus.bit_ready); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL mr_addr: got %0d expected 0", bus.address); end
    checks++; if (bus.blank_DA_n !== 1'b0) begin errors++; $display("FAIL mr_blank: got %b expected 0", bus.blank_DA_n); end
    checks++; if (bus.bit_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b expected 1", bus.bit_ready); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL mr_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1);
    step(1'b1);
    checks++; if (dbg_state !== ST_IDLE || bus.address !== 5'd0) begin errors++; $display("FAIL mr_after: got state=%0d addr=%0d expected 0 0", dbg_state, bus.address); end
  endtask

  initial begin
    test_reset();
    test_absolute();
    test_relative();
    test_underrun_bypass();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bdpsk_symbol_sequencer.md
BDPSK_SYMBOL_SEQUENCER -- requirements
Module: bdpsk_symbol_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 5, sine-ROM address width (32 samples per carrier period).
REQ-002 Parameter: CYC_PER_SYM, default 4, carrier periods per transmitted symbol (range 1..15).
REQ-003 clk  input  1  system clock; also the DA sample clock.
REQ-004 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 en  input  1  transmit enable, level.
REQ-006 re  input  1  1 = relative (differential) encoding, 0 = absolute; sampled only at symbol start.
REQ-007 bit_in  input  1  data bit to transmit.
REQ-008 bit_valid  input  1  bit_in valid.
REQ-009 bit_ready  output  1  sequencer accepts bit_in this cycle.
REQ-010 address  output  ADDR_W  sine-ROM address.
REQ-011 clk_DA  output  1  DA clock, equal to clk.
REQ-012 blank_DA_n  output  1  DA blanking, active-low.
REQ-013 sync_DA_n  output  1  DA sync, tied 1.
REQ-014 sym_start  output  1  one-cycle pulse in the cycle the first sample of a symbol is presented.
REQ-015 underrun  output  1  one-cycle pulse when a symbol starts with the holding register empty.

Function
REQ-016 The block SHALL contain a one-entry bit holding register; bit_ready = holding register empty OR being consumed this cycle; a transfer occurs when bit_valid and bit_ready are both 1.
REQ-017 FSM states SHALL be IDLE, RUN, FINISH.
REQ-018 IDLE: address = 0, blank_DA_n = 0; go to RUN in the cycle after en = 1 AND holding register full.
REQ-019 RUN: the sample counter (ADDR_W bits) increments every cycle and wraps from 31 to 0; the carrier counter increments on each wrap; a symbol ends when the carrier counter reaches CYC_PER_SYM-1 and the sample counter reaches 31.
REQ-020 At every symbol start the block SHALL consume the held bit b and update phase: re = 1 -> phase <= phase XOR b; re = 0 -> phase <= b.
REQ-021 address SHALL equal sample counter + (phase ? 2^(ADDR_W-1) : 0), modulo 2^ADDR_W, so that phase 1 is a 180-degree shift.
REQ-022 A phase change SHALL only take effect at a symbol boundary, never mid-symbol.
REQ-023 Holding register empty at a symbol start -> b = 0 is used (phase unchanged for re = 1), underrun pulses, and RUN continues.
REQ-024 en = 0 during RUN -> go to FINISH; the current symbol completes, then IDLE; en returning to 1 during FINISH -> back to RUN with no gap.
REQ-025 A bit transferred in the same cycle as its symbol start SHALL be used for that symbol (bypass).
REQ-026 blank_DA_n SHALL be 1 in RUN and FINISH.
REQ-027 address SHALL be registered; sym_start SHALL be aligned with the address of sample 0 of the symbol.

Reset
REQ-028 On reset_n = 0: state IDLE, address 0, phase 0, counters 0, holding register empty, bit_ready 1, blank_DA_n 0, sym_start 0, underrun 0.
REQ-029 Reset asserted mid-symbol SHALL abort immediately with no completion of the symbol.

Structure
REQ-030 Shared package: ADDR_W default, half-period offset constant (16), FSM state enumeration.
REQ-031 One sub-module, bdpsk_bit_buffer (holding register plus handshake); counters, FSM, and encoder stay in the top level.

Verification
REQ-032 Absolute mode: re = 0, CYC_PER_SYM = 4, bits 1,0,1 -> address sequence 16..15 (128 cycles), 0..31 (128), 16..15 (128); sym_start at cycles 0, 128, 256 of RUN.
REQ-033 Relative mode: re = 1, bits 1,1,0 from phase 0 -> phases 1,0,0; symbol starts at addresses 16, 0, 0.
REQ-034 Underrun: one bit only, en held 1 -> the second symbol starts with underrun = 1 and phase unchanged.
REQ-035 Graceful stop: en dropped at sample 40 of a symbol -> the symbol completes to 128 samples, then blank_DA_n = 0 and address = 0.
REQ-036 Mid-symbol reset: reset_n low at sample 70 -> address 0, blank_DA_n 0, bit_ready 1 in the same cycle.
